// File: rtl/gray_step_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_monitor_if
// Description : Sample stream in / decoded result out for gray_step_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_step_monitor_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 g_valid;
    logic [WIDTH-1:0]     g_in;
    logic                 b_valid;
    logic [WIDTH-1:0]     b_out;
    logic                 step_ok;
    logic                 step_err;
    logic                 dir_up;
    logic                 wrap;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output g_valid, g_in,
        input  b_valid, b_out, step_ok, step_err, dir_up, wrap, locked, err_count
    );

    modport slave (
        input  g_valid, g_in,
        output b_valid, b_out, step_ok, step_err, dir_up, wrap, locked, err_count
    );
endinterface
`default_nettype wire

// File: rtl/gray_step_monitor.sv
`default_nettype none
// ============================================================================
// Module      : gray_step_monitor
// Description : Decodes a gray-coded sample stream and checks +/-1 steps.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_step_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clear,
    gray_step_monitor_if.slave bus
);

    localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};
    localparam logic [WIDTH-1:0]     c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_g;
    logic [WIDTH-1:0]     w_s1_bin;

    logic                 r_b_valid;
    logic [WIDTH-1:0]     r_b_out;
    logic [WIDTH-1:0]     r_b_prev;
    logic                 r_step_ok;
    logic                 r_step_err;
    logic                 r_wrap;
    logic                 r_dir_up;
    logic                 r_locked;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_step_ok;
    logic                 w_step_err;
    logic                 w_wrap;
    logic                 w_dir_up_nxt;
    logic                 w_locked_nxt;
    logic [WIDTH-1:0]     w_inc;
    logic [WIDTH-1:0]     w_dec;

    // Stage 1: capture the raw gray sample; clear drops whatever arrives.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
        end else begin
            r_s1_valid <= bus.g_valid;
            r_s1_g     <= bus.g_in;
        end
    end

    // Each binary bit is the XOR of all gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_gray2bin
        assign w_s1_bin[i] = ^r_s1_g[WIDTH-1:i];
    end

    assign w_inc = r_b_prev + c_one;
    assign w_dec = r_b_prev - c_one;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_step_ok    = 1'b0;
        w_step_err   = 1'b0;
        w_wrap       = 1'b0;
        w_dir_up_nxt = r_dir_up;
        w_locked_nxt = r_locked;
        if (r_s1_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt  = ST_TRACK;
                    w_locked_nxt = 1'b1;
                end
                ST_TRACK: begin
                    if (w_s1_bin == w_inc) begin
                        w_step_ok    = 1'b1;
                        w_dir_up_nxt = 1'b1;
                        w_wrap       = &r_b_prev;
                    end else if (w_s1_bin == w_dec) begin
                        w_step_ok    = 1'b1;
                        w_dir_up_nxt = 1'b0;
                        w_wrap       = ~|r_b_prev;
                    end else if (w_s1_bin != r_b_prev) begin
                        w_step_err   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Stage 2: decoded value, flags and tracking state. b_out/dir_up survive clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_valid   <= 1'b0;
            r_b_out     <= '0;
            r_b_prev    <= '0;
            r_step_ok   <= 1'b0;
            r_step_err  <= 1'b0;
            r_wrap      <= 1'b0;
            r_dir_up    <= 1'b1;
            r_locked    <= 1'b0;
            r_err_count <= '0;
        end else if (clear) begin
            r_b_valid   <= 1'b0;
            r_step_ok   <= 1'b0;
            r_step_err  <= 1'b0;
            r_wrap      <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_b_valid  <= r_s1_valid;
            r_step_ok  <= w_step_ok;
            r_step_err <= w_step_err;
            r_wrap     <= w_wrap;
            r_dir_up   <= w_dir_up_nxt;
            r_locked   <= w_locked_nxt;
            if (r_s1_valid) begin
                r_b_out  <= w_s1_bin;
                r_b_prev <= w_s1_bin;
            end
            if (w_step_err && (r_err_count != c_err_max)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.b_valid   = r_b_valid;
    assign bus.b_out     = r_b_out;
    assign bus.step_ok   = r_step_ok;
    assign bus.step_err  = r_step_err;
    assign bus.wrap      = r_wrap;
    assign bus.dir_up    = r_dir_up;
    assign bus.locked    = r_locked;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_gray_step_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_step_monitor
// Description : Directed bench for gray_step_monitor (ERR_CNT_W=8 and =2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_step_monitor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   errors = 0;
    int   checks = 0;

    gray_step_monitor_if #(.WIDTH(4), .ERR_CNT_W(8)) bus  ();
    gray_step_monitor_if #(.WIDTH(4), .ERR_CNT_W(2)) bus2 ();

    gray_step_monitor #(.WIDTH(4), .ERR_CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    gray_step_monitor #(.WIDTH(4), .ERR_CNT_W(2)) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] g);
        bus.g_valid  = v;
        bus.g_in     = g;
        bus2.g_valid = v;
        bus2.g_in    = g;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic bv, input logic [3:0] bo,
                           input logic ok, input logic er, input logic wr,
                           input logic du, input logic lk);
        chk({tag, ".b_valid"},  {31'd0, bus.b_valid},  {31'd0, bv});
        chk({tag, ".b_out"},    {28'd0, bus.b_out},    {28'd0, bo});
        chk({tag, ".step_ok"},  {31'd0, bus.step_ok},  {31'd0, ok});
        chk({tag, ".step_err"}, {31'd0, bus.step_err}, {31'd0, er});
        chk({tag, ".wrap"},     {31'd0, bus.wrap},     {31'd0, wr});
        chk({tag, ".dir_up"},   {31'd0, bus.dir_up},   {31'd0, du});
        chk({tag, ".locked"},   {31'd0, bus.locked},   {31'd0, lk});
    endtask

    initial begin
        drive(1'b0, 4'b0000);
        tick(); tick();
        chk_out("reset", 0, 4'd0, 0, 0, 0, 1, 0);
        chk("reset.err_count", {24'd0, bus.err_count}, 32'd0);
        rst_n = 1'b1;

        // 1: counting up 0,1,2,3
        drive(1, 4'b0000); tick();
        drive(1, 4'b0001); tick();
        chk_out("t1.s0", 1, 4'd0, 0, 0, 0, 1, 1);
        drive(1, 4'b0011); tick();
        chk_out("t1.s1", 1, 4'd1, 1, 0, 0, 1, 1);
        drive(1, 4'b0010); tick();
        chk_out("t1.s2", 1, 4'd2, 1, 0, 0, 1, 1);
        drive(0, 4'b0000); tick();
        chk_out("t1.s3", 1, 4'd3, 1, 0, 0, 1, 1);
        chk("t1.err_count", {24'd0, bus.err_count}, 32'd0);
        tick();
        chk_out("t1.bubble", 0, 4'd3, 0, 0, 0, 1, 1);

        // 2: wrap up 15->0 then wrap down 0->15
        clear = 1'b1; tick(); clear = 1'b0;
        drive(1, 4'b1000); tick();
        drive(1, 4'b0000); tick();
        chk_out("t2.ref", 1, 4'd15, 0, 0, 0, 1, 1);
        drive(1, 4'b1000); tick();
        chk_out("t2.up", 1, 4'd0, 1, 0, 1, 1, 1);
        drive(0, 4'b0000); tick();
        chk_out("t2.down", 1, 4'd15, 1, 0, 1, 0, 1);
        tick();

        // 3: illegal jump, then saturation of the 2-bit counter
        drive(1, 4'b0000); tick();
        drive(1, 4'b0010); tick();
        chk_out("t3.wrapup", 1, 4'd0, 1, 0, 1, 1, 1);
        drive(0, 4'b0000); tick();
        chk_out("t3.jump", 1, 4'd3, 0, 1, 0, 1, 1);
        chk("t3.err_count", {24'd0, bus.err_count}, 32'd1);
        chk("t3.err_count_w2", {30'd0, bus2.err_count}, 32'd1);
        drive(1, 4'b1101); tick();
        drive(1, 4'b0010); tick();
        drive(1, 4'b1101); tick();
        drive(1, 4'b0010); tick();
        drive(1, 4'b1101); tick();
        drive(0, 4'b0000); tick();
        chk_out("t3.last", 1, 4'd9, 0, 1, 0, 1, 1);
        chk("t3.err_count6", {24'd0, bus.err_count}, 32'd6);
        chk("t3.saturate_w2", {30'd0, bus2.err_count}, 32'd3);

        // 4: repeat gives no flags, bubbles ignored, then down step
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4.clear_err", {24'd0, bus.err_count}, 32'd0);
        drive(1, 4'b0011); tick();
        drive(1, 4'b0011); tick();
        chk_out("t4.ref", 1, 4'd2, 0, 0, 0, 1, 1);
        drive(0, 4'b0000); tick();
        chk_out("t4.repeat", 1, 4'd2, 0, 0, 0, 1, 1);
        tick();
        chk_out("t4.idle", 0, 4'd2, 0, 0, 0, 1, 1);
        tick();
        drive(1, 4'b0001); tick();
        drive(0, 4'b0000); tick();
        chk_out("t4.down", 1, 4'd1, 1, 0, 0, 0, 1);
        chk("t4.err_count", {24'd0, bus.err_count}, 32'd0);

        // 5: clear drops a concurrent sample; next sample is a fresh reference
        drive(1, 4'b1101); tick();
        drive(0, 4'b0000); tick();
        chk_out("t5.err", 1, 4'd9, 0, 1, 0, 0, 1);
        chk("t5.err_count", {24'd0, bus.err_count}, 32'd1);
        clear = 1'b1;
        drive(1, 4'b0110); tick();
        clear = 1'b0;
        chk_out("t5.clear", 0, 4'd9, 0, 0, 0, 0, 0);
        chk("t5.clear_err", {24'd0, bus.err_count}, 32'd0);
        drive(0, 4'b0000); tick();
        chk_out("t5.dropped", 0, 4'd9, 0, 0, 0, 0, 0);
        drive(1, 4'b0111); tick();
        drive(0, 4'b0000); tick();
        chk_out("t5.relock", 1, 4'd5, 0, 0, 0, 0, 1);

        // 6: reset with two samples in flight
        drive(1, 4'b0101); tick();
        drive(1, 4'b0100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_out("t6.reset", 0, 4'd0, 0, 0, 0, 1, 0);
        chk("t6.err_count", {24'd0, bus.err_count}, 32'd0);
        drive(0, 4'b0000); tick();
        chk_out("t6.flush1", 0, 4'd0, 0, 0, 0, 1, 0);
        tick();
        chk_out("t6.flush2", 0, 4'd0, 0, 0, 0, 1, 0);
        drive(1, 4'b0001); tick();
        drive(0, 4'b0000); tick();
        chk_out("t6.first", 1, 4'd1, 0, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
